// File: rtl/vram_arb.sv
// Single-port video RAM shared by a CPU req/ack port and a video burst prefetcher.
// Define VRAM_CPU_PRIO_EN to drop the low-water video priority so a pending CPU request always wins.
module vram_arb #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned LOW_WATER  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_din,
  input  logic [DATA_W/8-1:0] cpu_be,
  output logic                cpu_ack,
  output logic [DATA_W-1:0]   cpu_dout,
  input  logic                vid_start,
  input  logic [ADDR_W-1:0]   vid_base,
  input  logic [ADDR_W-1:0]   vid_len,
  input  logic                vid_rd,
  output logic                vid_valid,
  output logic [DATA_W-1:0]   vid_dout,
  output logic                vid_busy,
  output logic                vid_underrun
);

  localparam int unsigned BE_W      = DATA_W / 8;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned OCC_W     = PTR_W + 2;
  localparam int unsigned MEM_DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CPU_ACC = 2'd1,
    ST_VID_ACC = 2'd2
  } arb_state_e;

  arb_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   vaddr_q, vaddr_d;
  logic [ADDR_W-1:0]   remaining_q, remaining_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                underrun_q, underrun_d;
  logic [DATA_W-1:0]   cpu_dout_q;
  logic [DATA_W-1:0]   vid_rdata_q;

  logic [DATA_W-1:0]   mem      [MEM_DEPTH];
  logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];

  logic                inflight_c;
  logic [OCC_W-1:0]    occ_c;
  logic                cpu_ok_c;
  logic                vid_pend_c;
  logic                vid_urgent_c;
  logic                vid_room_c;
  logic                cpu_issue_c;
  logic                vid_issue_c;
  logic                mem_wr_c;
  logic                cpu_rd_c;
  logic [ADDR_W-1:0]   mem_addr_c;
  logic                push_c;
  logic                pop_c;

  // Arbiter inputs; occupancy counts the read still in flight against FIFO capacity.
  always_comb begin
    inflight_c = (state_q == ST_VID_ACC);
    occ_c      = OCC_W'(count_q) + OCC_W'(inflight_c);
    cpu_ok_c   = cpu_req && !cpu_ack_q;
    vid_pend_c = (remaining_q != '0);
    vid_room_c = vid_pend_c && (occ_c < OCC_W'(FIFO_DEPTH));
`ifdef VRAM_CPU_PRIO_EN
    vid_urgent_c = 1'b0;
`else
    vid_urgent_c = vid_pend_c && (occ_c <= OCC_W'(LOW_WATER));
`endif
  end

  // State register: records which access was issued in the previous cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: the access issued in the current cycle.
  always_comb begin
    state_d = ST_IDLE;
    if (vid_start) begin
      if (cpu_ok_c) state_d = ST_CPU_ACC;
    end else if (vid_urgent_c) begin
      state_d = ST_VID_ACC;
    end else if (cpu_ok_c) begin
      state_d = ST_CPU_ACC;
    end else if (vid_room_c) begin
      state_d = ST_VID_ACC;
    end
  end

  // Output decode of the chosen access onto the memory port.
  always_comb begin
    cpu_issue_c = (state_d == ST_CPU_ACC);
    vid_issue_c = (state_d == ST_VID_ACC);
    mem_wr_c    = cpu_issue_c && cpu_we;
    cpu_rd_c    = cpu_issue_c && !cpu_we;
    mem_addr_c  = vid_issue_c ? vaddr_q : cpu_addr;
  end

  // Burst counters, FIFO pointers and flags.
  always_comb begin
    cpu_ack_d   = cpu_issue_c;
    push_c      = inflight_c && !vid_start;
    pop_c       = vid_rd && (count_q != '0) && !vid_start;
    vaddr_d     = vaddr_q;
    remaining_d = remaining_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    underrun_d  = underrun_q;
    if (vid_start) begin
      vaddr_d     = vid_base;
      remaining_d = vid_len;
      count_d     = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      underrun_d  = 1'b0;
    end else begin
      if (vid_issue_c) begin
        vaddr_d     = vaddr_q + ADDR_W'(1);
        remaining_d = remaining_q - ADDR_W'(1);
      end
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
      if (vid_rd && (count_q == '0)) underrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vaddr_q     <= '0;
      remaining_q <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cpu_ack_q   <= 1'b0;
      underrun_q  <= 1'b0;
      cpu_dout_q  <= '0;
    end else begin
      vaddr_q     <= vaddr_d;
      remaining_q <= remaining_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cpu_ack_q   <= cpu_ack_d;
      underrun_q  <= underrun_d;
      if (cpu_rd_c) cpu_dout_q <= mem[mem_addr_c];
    end
  end

  // Memory array, video read register and FIFO storage carry no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (mem_wr_c && cpu_be[i]) mem[mem_addr_c][8*i +: 8] <= cpu_din[8*i +: 8];
    end
    if (vid_issue_c) vid_rdata_q <= mem[mem_addr_c];
    if (push_c) fifo_mem[wr_ptr_q] <= vid_rdata_q;
  end

  assign cpu_ack      = cpu_ack_q;
  assign cpu_dout     = cpu_dout_q;
  assign vid_valid    = (count_q != '0);
  assign vid_dout     = vid_valid ? fifo_mem[rd_ptr_q] : '0;
  assign vid_busy     = vid_pend_c || inflight_c;
  assign vid_underrun = underrun_q;

endmodule

// File: doc/vram_arb.md
Name: vram_arb

Overview:
- Parametrised single-clock video RAM with one physical memory port, shared by a CPU port and a video burst-read port.
- CPU port: req/ack handshake with byte-lane writes.
- Video port: fetches a programmed run of words into a small prefetch FIFO that the display pipeline pops at its own pace.
- Successor to the fixed 16-bit dual-clock VRAM. Adds arbitration, burst prefetch and parametrised width, depth and FIFO size.

Parameters:
- DATA_W, 16, memory word width; must be a multiple of 8.
- ADDR_W, 14, word address width; memory depth is 2**ADDR_W words.
- FIFO_DEPTH, 8, video prefetch FIFO entries; power of two, at least 4.
- LOW_WATER, 2, FIFO occupancy (including in-flight reads) at or below which video takes priority over CPU.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; valid with cpu_req.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_din  in  DATA_W  CPU write data.
- cpu_be  in  DATA_W/8  byte enables; bit i controls byte i.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_dout  out  DATA_W  read data; valid while cpu_ack=1, held otherwise.
- vid_start  in  1  pulse: flush FIFO, load vid_base and vid_len.
- vid_base  in  ADDR_W  first word of the burst.
- vid_len  in  ADDR_W  words to fetch; 0 = none.
- vid_rd  in  1  pop FIFO head.
- vid_valid  out  1  FIFO non-empty.
- vid_dout  out  DATA_W  FIFO head; forced to 0 when vid_valid=0.
- vid_busy  out  1  burst words remaining or reads in flight.
- vid_underrun  out  1  sticky: vid_rd seen while empty.

Behaviour:
- Reset (async assert, sync release): cpu_ack=0, cpu_dout=0, vid_valid=0, vid_dout=0, vid_busy=0, vid_underrun=0. FIFO is empty, the burst counter is 0 and the arbiter is in IDLE. Memory contents are not reset and are undefined.
- Memory: at most one access per cycle; synchronous read with 1-cycle latency. On a write, byte i is written only if cpu_be[i]=1. cpu_be=0 on a write is a legal no-op that still acks.
- Arbiter states:
  - IDLE: no access this cycle.
  - CPU_ACC: CPU access issued.
  - VID_ACC: video read issued.
  - The state is re-decided every cycle.
- Arbitration order each cycle:
  1. Video, if remaining>0 and (fifo_count + inflight) <= LOW_WATER.
  2. Otherwise CPU, if cpu_req=1 and the CPU is not in its ack cycle.
  3. Otherwise video, if remaining>0 and (fifo_count + inflight) < FIFO_DEPTH.
  4. Otherwise IDLE.
- CPU handshake:
  - Access issued in cycle N; cpu_ack=1 in cycle N+1. For reads, cpu_dout carries the data in that cycle.
  - No CPU access is issued in cycle N+1, even if cpu_req is still high. The requester drops req or presents the next request from N+2.
  - A write followed by a read of the same address returns the new data.
- Video fetch:
  - Each VID_ACC reads at the burst address, then address+1 (wraps modulo 2**ADDR_W) and remaining-1.
  - Data is pushed into the FIFO one cycle after issue.
  - The FIFO never overflows, because in-flight reads are counted against capacity.
- vid_start sampled in cycle N:
  - FIFO is emptied and any in-flight read is discarded (not pushed).
  - Burst registers are loaded from vid_base/vid_len; vid_underrun is cleared.
  - No video issue occurs in cycle N; a CPU access may still issue.
  - With no CPU contention: first issue at N+1, push at N+2, vid_valid=1 at N+3.
- Pop: on vid_rd=1 with vid_valid=1, the head advances. A simultaneous push and pop leaves the count unchanged.
- vid_rd=1 while empty: no pop; vid_underrun is set and held until vid_start or reset.
- vid_busy = (remaining != 0) or (inflight != 0).
- Reset mid-burst or mid-CPU-access: the access is abandoned and no ack is produced.

Optional Feature:
- Macro: VRAM_CPU_PRIO_EN.
- Defined: the low-water video rule (step 1) is removed; a pending CPU request always wins, and video uses only step 3. The underrun flag behaves as normal.
- Undefined: arbitration order as specified in Behaviour.

Test Plan:
1. Reset, then CPU write addr 0x0010 data 0xA55A be=2'b11, then read 0x0010 → each ack exactly 1 cycle after issue; read cpu_dout=0xA55A.
2. Write 0xFFFF at 0x0020, then 0x1200 with be=2'b10, then read → cpu_dout=0x12FF.
3. Preload words 0x0100..0x0107 with values 0..7. vid_start base=0x0100 len=8, vid_rd held 1 from the first vid_valid → vid_dout sequence 0..7; vid_valid first high 3 cycles after start; vid_busy falls after the last issue+1.
4. vid_len=12, FIFO_DEPTH=8, no pops → fetch stalls with count=8 and remaining=4; popping 4 entries resumes fetches; total 12 words, no loss or duplication.
5. Base=2**ADDR_W-2, len=4 → words read from addresses top-1, top, 0, 1 in order.
6. Continuous cpu_req plus active burst with an empty FIFO → video wins until occupancy exceeds 2, then CPU gets served. vid_rd while empty → vid_underrun=1 until the next vid_start. With VRAM_CPU_PRIO_EN defined, the CPU wins every eligible cycle.
